// File: rtl/mem_read_arbiter_pkg.sv
// Shared definitions for the memory read-port arbiter and its clients.
// Holds the owner encodings (also used as the arbiter state), default widths
// and the slot-winner selection rule.
package mem_read_arbiter_pkg;

  localparam int DEF_AW         = 16;
  localparam int DEF_DW         = 16;
  localparam int DEF_MAX_STREAK = 4;

  // Who owns the single outstanding memory request.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Load wins a contested slot unless fetch has already been passed over
  // the maximum number of times in a row.
  function automatic owner_e pick_winner(input logic f_re,
                                         input logic d_re,
                                         input logic streak_full);
    owner_e w;
    w = OWN_NONE;
    if (f_re && (!d_re || streak_full)) begin
      w = OWN_F;
    end else if (d_re) begin
      w = OWN_D;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_read_arbiter.sv
// Purpose : shares one memory read port between fetch (f_*) and load (d_*),
//           load-priority with a bounded fetch starvation streak, one request
//           outstanding at a time.
// Ports   : f_re/f_raddr -> f_ready, d_re/d_raddr -> d_ready (per-client
//           request/response), cl_addr_out/cl_data_out broadcast response,
//           mem_re/mem_raddr -> memory, mem_ready/mem_addr_out/mem_data_out
//           <- memory, owner = current outstanding owner.
// Latency : zero added; grant, mem_re and ready routing are combinational,
//           only state and streak are registered. A client not granted gets
//           no ready and must keep re asserted.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_re,
  input  logic [AW-1:0] f_raddr,
  output logic          f_ready,
  input  logic          d_re,
  input  logic [AW-1:0] d_raddr,
  output logic          d_ready,
  output logic [AW-1:0] cl_addr_out,
  output logic [DW-1:0] cl_data_out,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic          mem_ready,
  input  logic [AW-1:0] mem_addr_out,
  input  logic [DW-1:0] mem_data_out,
  output logic [1:0]    owner
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  owner_e        r_state;
  owner_e        w_state_nxt;
  owner_e        w_winner;
  logic [SW-1:0] r_streak;
  logic [SW-1:0] w_streak_nxt;
  logic          w_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= OWN_NONE;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    mem_re       = 1'b0;
    // A new request can go out when idle, or in the very cycle the current
    // one completes (memory accepts on the same mem_ready).
    w_slot       = (r_state == OWN_NONE) || mem_ready;
    w_winner     = pick_winner(f_re, d_re, r_streak == STREAK_MAX);
    mem_raddr    = (w_winner == OWN_F) ? f_raddr : d_raddr;

    if (w_slot) begin
      w_state_nxt = w_winner;
      // rst_n gate keeps mem_re low while reset is held even if a client
      // is already requesting.
      mem_re      = (w_winner != OWN_NONE) && rst_n;
      case (w_winner)
        OWN_F: w_streak_nxt = '0;
        OWN_D: begin
          if (!f_re) begin
            w_streak_nxt = '0;
          end else if (r_streak != STREAK_MAX) begin
            w_streak_nxt = r_streak + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // mem_ready while IDLE matches no owner and is dropped here.
  assign f_ready     = (r_state == OWN_F) && mem_ready;
  assign d_ready     = (r_state == OWN_D) && mem_ready;
  assign cl_addr_out = mem_addr_out;
  assign cl_data_out = mem_data_out;
  assign owner       = r_state;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized bench for mem_read_arbiter: transaction-level reference model
// feeds expectation queues; a negedge monitor pops and compares whenever the
// DUT issues to memory or returns a response.
module tb_mem_read_arbiter;
  import mem_read_arbiter_pkg::*;

  localparam int AW = DEF_AW;
  localparam int DW = DEF_DW;
  localparam int MS = DEF_MAX_STREAK;
  localparam int NCYC = 600;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_re = 1'b0, d_re = 1'b0;
  logic [AW-1:0] f_raddr = '0, d_raddr = '0;
  logic          f_ready, d_ready;
  logic [AW-1:0] cl_addr_out;
  logic [DW-1:0] cl_data_out;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr_out = '0;
  logic [DW-1:0] mem_data_out = '0;
  logic [1:0]    owner;

  mem_read_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_re(f_re), .f_raddr(f_raddr), .f_ready(f_ready),
    .d_re(d_re), .d_raddr(d_raddr), .d_ready(d_ready),
    .cl_addr_out(cl_addr_out), .cl_data_out(cl_data_out),
    .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_ready(mem_ready), .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .owner(owner)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]    who;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rsp_t;

  logic [AW-1:0] iss_q[$];
  logic [1:0]    own_q[$];
  rsp_t          rsp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h expected none", name, act);
  endtask

  // Memory returns a byte-swapped, scrambled copy of the address as data.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  // ---------------- memory model (reacts to what the DUT actually issues)
  logic          mp_pend = 1'b0;
  int            mp_cnt  = 0;
  logic [AW-1:0] mp_addr = '0;
  logic          phase_fast = 1'b0;

  always @(negedge clk) begin
    if (rst_n && mem_re) begin
      mp_pend = 1'b1;
      mp_cnt  = phase_fast ? 1 : $urandom_range(1, 3);
      mp_addr = mem_raddr;
    end
  end

  // ---------------- reference model state
  logic [1:0]    m_out = OWN_NONE;   // client whose request is outstanding
  int            m_passed = 0;       // loads granted in a row while fetch waited
  logic [AW-1:0] m_addr = '0;
  logic          f_want = 1'b0, d_want = 1'b0;
  logic [AW-1:0] f_addr = '0, d_addr = '0;
  int            f_pct = 50, d_pct = 50;

  // ---------------- monitor
  always @(negedge clk) begin
    rsp_t r;
    if (!rst_n) begin
      chk("rst_mem_re", mem_re, 0);
      chk("rst_f_ready", f_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_owner", owner, 0);
    end else begin
      if (own_q.size() != 0) chk("owner", owner, own_q.pop_front());
      if (mem_re) begin
        if (iss_q.size() == 0) fail_note("issue_unexpected", mem_raddr);
        else chk("issue_addr", mem_raddr, iss_q.pop_front());
      end
      if (iss_q.size() != 0) begin
        chk("issue_missing_mem_re", mem_re, 1);
        iss_q.delete();
      end
      if (f_ready && d_ready) fail_note("both_ready", {f_ready, d_ready});
      if (f_ready || d_ready) begin
        if (rsp_q.size() == 0) fail_note("rsp_unexpected", {d_ready, f_ready});
        else begin
          r = rsp_q.pop_front();
          chk("rsp_client", {d_ready, f_ready}, r.who);
          chk("rsp_addr", cl_addr_out, r.addr);
          chk("rsp_data", cl_data_out, r.data);
        end
      end
      if (rsp_q.size() != 0) begin
        chk("rsp_missing_ready", {d_ready, f_ready}, rsp_q[0].who);
        rsp_q.delete();
      end
    end
  end

  // ---------------- stimulus + reference model
  initial begin
    logic [1:0] win;
    logic       f_free, d_free;
    int         rst_hold;
    logic       rst_done;
    rst_hold = 0;
    rst_done = 1'b0;
    // Fetch is waiting on address 0 when reset releases.
    f_want = 1'b1;
    f_addr = '0;
    f_re   = 1'b1;
    repeat (3) @(posedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 0) rst_n = 1'b1;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end
      phase_fast = (cyc >= 200 && cyc < 300);
      f_pct = phase_fast ? 100 : 50;
      d_pct = phase_fast ? 100 : 60;

      // memory drive
      mem_ready = 1'b0;
      if (rst_n && mp_pend) begin
        mp_cnt--;
        if (mp_cnt == 0) begin
          mem_ready    = 1'b1;
          mem_addr_out = mp_addr;
          mem_data_out = mem_fn(mp_addr);
          mp_pend      = 1'b0;
        end
      end else if (rst_n && !phase_fast && $urandom_range(0, 5) == 0) begin
        mem_ready    = 1'b1;
        mem_addr_out = AW'($urandom);
        mem_data_out = DW'($urandom);
      end

      // clients: fetch addresses have bit15=0, load addresses bit15=1
      f_free = (m_out != OWN_F) || mem_ready;
      d_free = (m_out != OWN_D) || mem_ready;
      if (rst_n) begin
        if (!f_want && f_free && $urandom_range(0, 99) < f_pct) begin
          f_want = 1'b1;
          f_addr = {1'b0, 15'($urandom)};
        end else if (f_want && $urandom_range(0, 5) == 0) begin
          f_addr = {1'b0, 15'($urandom)};   // redirect while waiting
        end
        if (!d_want && d_free && $urandom_range(0, 99) < d_pct) begin
          d_want = 1'b1;
          d_addr = {1'b1, 15'($urandom)};
        end
      end
      f_re    = f_want;
      d_re    = d_want;
      f_raddr = f_want ? f_addr : AW'($urandom);
      d_raddr = d_want ? d_addr : AW'($urandom);
      #1;

      if (rst_n && !rst_done && cyc >= 350 && m_out == OWN_D && !mem_ready) begin
        // Abandon an outstanding load with fetch pending.
        f_want  = 1'b1;
        f_re    = 1'b1;
        f_raddr = f_addr;
        rst_n   = 1'b0;
        #1;
        chk("async_rst_mem_re", mem_re, 0);
        chk("async_rst_f_ready", f_ready, 0);
        chk("async_rst_d_ready", d_ready, 0);
        chk("async_rst_owner", owner, 0);
        iss_q.delete();
        rsp_q.delete();
        own_q.delete();
        m_out    = OWN_NONE;
        m_passed = 0;
        d_want   = 1'b0;
        d_re     = 1'b0;
        mp_pend  = 1'b0;
        rst_hold = 2;
        rst_done = 1'b1;
      end else if (rst_n) begin
        own_q.push_back(m_out);
        if (mem_ready && m_out != OWN_NONE)
          rsp_q.push_back('{who: m_out, addr: m_addr, data: mem_fn(m_addr)});
        if (m_out == OWN_NONE || mem_ready) begin
          win = OWN_NONE;
          if (f_want && (!d_want || m_passed >= MS)) win = OWN_F;
          else if (d_want) win = OWN_D;
          if (win == OWN_F) begin
            m_addr   = f_addr;
            f_want   = 1'b0;
            m_passed = 0;
          end else if (win == OWN_D) begin
            m_addr   = d_addr;
            d_want   = 1'b0;
            m_passed = f_want ? ((m_passed < MS) ? m_passed + 1 : MS) : 0;
          end
          if (win != OWN_NONE) iss_q.push_back(m_addr);
          m_out = win;
        end
      end
    end

    @(negedge clk);
    #1;
    chk("mid_run_reset_taken", rst_done, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares the single instruction/data memory read port between the fetch unit and the load unit. Each client sees its own copy of the memory read protocol (re/raddr out, ready/addr_out/data_out in), so fetch connects unchanged. Arbitration is load-priority with a bounded starvation limit for fetch, and one request is outstanding at a time. Sits between the two clients and the memory read port.

## Interface
- AW, 16, address width
- DW, 16, data width
- MAX_STREAK, 4, max consecutive load grants while fetch waits (≥1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- f_re  in  1  fetch request valid
- f_raddr  in  AW  fetch address
- f_ready  out  1  response for fetch's outstanding request valid this cycle
- d_re  in  1  load request valid
- d_raddr  in  AW  load address
- d_ready  out  1  response for load's outstanding request valid this cycle
- cl_addr_out  out  AW  response address, broadcast to both clients (= mem_addr_out)
- cl_data_out  out  DW  response data, broadcast to both clients (= mem_data_out)
- mem_re  out  1  issue request to memory
- mem_raddr  out  AW  address of issued request
- mem_ready  in  1  memory response valid; memory accepts a new request this same cycle
- mem_addr_out  in  AW  address of response
- mem_data_out  in  DW  response data
- owner  out  2  current outstanding owner: 0 none, 1 fetch, 2 load

## Operation
- States: IDLE (nothing outstanding), BUSY_F, BUSY_D. owner encodes state.
- Issue slot exists when state==IDLE, or state is BUSY_x and mem_ready=1 (back-to-back).
- Slot winner: only one re high → that client; both high → load, unless streak==MAX_STREAK, then fetch; neither → no issue.
- On issue: mem_re=1, mem_raddr=winner's raddr (combinational pass-through); next state BUSY_F or BUSY_D.
- In a slot with no winner: mem_re=0, next state IDLE.
- Response routing: BUSY_F & mem_ready → f_ready=1; BUSY_D & mem_ready → d_ready=1; never both.
- Client may assert re in the same cycle its ready is high; that request competes in the same slot.
- A client whose re is not granted receives no ready and must hold re; addr may change (fetch redirect) — the value sampled at grant is the one issued.
- Streak counter, width clog2(MAX_STREAK+1), saturates at MAX_STREAK: load issue with f_re=1 → +1; fetch issue → 0; load issue with f_re=0 → 0.
- mem_ready in IDLE: dropped, no client ready, state stays IDLE.
- Memory shares rst_n; no response is expected across reset.

## Timing
- Reset (rst_n low, async): state IDLE, streak 0; mem_re, f_ready, d_ready forced 0; owner 0.
- Zero added latency: grant, mem_re and ready routing are combinational; only state and streak are registered.
- Issue in cycle T, response in cycle T+L (L ≥1 set by memory); next issue possible in cycle T+L.
- First request after reset: issued in the first cycle after rst_n deasserts with any re high, no mem_ready needed.
- Reset mid-transaction: outstanding request abandoned; no ready is delivered for it.

## Structure
- Shared package: owner encodings (OWN_NONE=0, OWN_F=1, OWN_D=2) and the default widths, reused by fetch/load and the bench.
- Single module; grant logic may be a small combinational function. No sub-module required.

## Test plan
- Reset release with f_re=1, f_raddr=0x0000, L=1 → mem_re=1, mem_raddr=0x0000 in cycle 0; next cycle mem_ready, data 0xBEEF → f_ready=1, cl_data_out=0xBEEF, owner=1.
- Both requesting, d_raddr=0x8000, f_raddr=0x0010 → load issued first, d_ready on its response, fetch issued in that same response cycle.
- d_re held 1, f_re held 1, MAX_STREAK=4, L=1 → grant sequence D,D,D,D,F,D,D,D,D,F; fetch never waits more than 4 grants.
- L=3, fetch outstanding, d_re rises mid-wait → no mem_re until mem_ready in cycle T+3; d_ready never asserted for fetch's data.
- mem_ready pulsed in IDLE with no request → f_ready=d_ready=0, owner stays 0.
- rst_n dropped while owner=2 → outputs 0 immediately (async); after release, pending f_re issued at once, no d_ready delivered for the abandoned load.
